updown_digit_counter: RTL and testbench

Parametrised multi-digit up/down counter, BCD or hex per digit, with synchronous load, count enable, and wrap or saturate at the limits. It drives a time-multiplexed 7-segment display: a scan counter selects one digit at a time, and that digit is decoded onto SEG. It is the next-generation counter/display block for top-level board I/O, fed from SWI and driving SEG/LED.

---
 rtl/counter_pkg.sv | 58 +++++
 rtl/seg7_decoder.sv | 11 +
 rtl/updown_digit_counter.sv | 174 +++++++++++++++++
 tb/tb_updown_digit_counter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared digit widths, limits and 7-segment encodings for the up/down digit counter.
package counter_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned BCD_TOP = 9;
    localparam int unsigned HEX_TOP = 15;
    localparam int unsigned SEG_W   = 7;

    typedef logic [DIGIT_W-1:0] digit_t;
    typedef logic [SEG_W-1:0]   segs_t;

    // Display payload as driven onto the board pins: {dp, g, f, e, d, c, b, a}
    typedef struct packed {
        logic  dp;
        segs_t segs;
    } seg_bus_t;

    localparam segs_t SEG_0 = 7'h3F;
    localparam segs_t SEG_1 = 7'h06;
    localparam segs_t SEG_2 = 7'h5B;
    localparam segs_t SEG_3 = 7'h4F;
    localparam segs_t SEG_4 = 7'h66;
    localparam segs_t SEG_5 = 7'h6D;
    localparam segs_t SEG_6 = 7'h7D;
    localparam segs_t SEG_7 = 7'h07;
    localparam segs_t SEG_8 = 7'h7F;
    localparam segs_t SEG_9 = 7'h6F;
    localparam segs_t SEG_A = 7'h77;
    localparam segs_t SEG_B = 7'h7C;
    localparam segs_t SEG_C = 7'h39;
    localparam segs_t SEG_D = 7'h5E;
    localparam segs_t SEG_E = 7'h79;
    localparam segs_t SEG_F = 7'h71;

    function automatic segs_t digit_to_seg(input digit_t d);
        segs_t s;
        case (d)
            4'h0:    s = SEG_0;
            4'h1:    s = SEG_1;
            4'h2:    s = SEG_2;
            4'h3:    s = SEG_3;
            4'h4:    s = SEG_4;
            4'h5:    s = SEG_5;
            4'h6:    s = SEG_6;
            4'h7:    s = SEG_7;
            4'h8:    s = SEG_8;
            4'h9:    s = SEG_9;
            4'hA:    s = SEG_A;
            4'hB:    s = SEG_B;
            4'hC:    s = SEG_C;
            4'hD:    s = SEG_D;
            4'hE:    s = SEG_E;
            default: s = SEG_F;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex digit to 7-segment (gfedcba, active-high) decoder.
module seg7_decoder
    import counter_pkg::*;
(
    input  digit_t digit,
    output segs_t  segments_c
);

    assign segments_c = digit_to_seg(digit);

endmodule

// File: rtl/updown_digit_counter.sv
// Multi-digit BCD/hex up/down counter with wrap/saturate limits and a
// time-multiplexed 7-segment scan of the current count.
module updown_digit_counter
    import counter_pkg::*;
#(
    parameter int unsigned NDIGITS  = 2,
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic                       clk_2,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       up,
    input  logic                       load,
    input  logic [DIGIT_W*NDIGITS-1:0] data_in,
    input  logic                       bcd_mode,
    input  logic                       saturate,
    output logic [DIGIT_W*NDIGITS-1:0] count,
    output logic                       tc,
    output logic                       wrap,
    output logic [7:0]                 seg,
    output logic [NDIGITS-1:0]         dig_sel
);

    localparam int unsigned CNT_W = DIGIT_W * NDIGITS;
    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    digit_t up_d [NDIGITS];
    digit_t dn_d [NDIGITS];
    digit_t ld_d [NDIGITS];

    logic [CNT_W-1:0] up_vec;
    logic [CNT_W-1:0] dn_vec;
    logic [CNT_W-1:0] ld_vec;
    logic [CNT_W-1:0] max_val;
    logic             up_limit;
    logic             dn_limit;

    logic [CNT_W-1:0] count_next;
    logic             wrap_next;

    logic [DIV_W-1:0]   div_q;
    logic [DIV_W-1:0]   div_next;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   idx_next;
    logic [NDIGITS-1:0] dig_sel_next;
    seg_bus_t           seg_next;
    digit_t             sel_digit;
    segs_t              sel_segs;

    // Per-digit ripple carry (up) and borrow (down); stale BCD digits >9 act as 9 going up.
    for (genvar i = 0; i < NDIGITS; i++) begin : g_digit
        digit_t cur;
        digit_t eff;
        digit_t top_val;
        digit_t din;
        logic   stale;
        logic   cin;
        logic   bin;
        logic   cout;
        logic   bout;

        assign cur     = count[i*DIGIT_W +: DIGIT_W];
        assign din     = data_in[i*DIGIT_W +: DIGIT_W];
        assign top_val = bcd_mode ? DIGIT_W'(BCD_TOP) : DIGIT_W'(HEX_TOP);
        assign stale   = bcd_mode && (cur > DIGIT_W'(BCD_TOP));
        assign eff     = stale ? DIGIT_W'(BCD_TOP) : cur;

        if (i == 0) begin : g_lsd
            assign cin = 1'b1;
            assign bin = 1'b1;
        end else begin : g_upper
            assign cin = g_digit[i-1].cout;
            assign bin = g_digit[i-1].bout;
        end

        assign cout = cin && (eff == top_val);
        assign bout = bin && (cur == '0);

        assign up_d[i] = !cin ? cur
                       : (eff == top_val) ? '0
                       : eff + DIGIT_W'(1);

        assign dn_d[i] = !bin ? cur
                       : (cur == '0) ? top_val
                       : stale ? DIGIT_W'(BCD_TOP - 1)
                       : cur - DIGIT_W'(1);

        assign ld_d[i] = (bcd_mode && (din > DIGIT_W'(BCD_TOP))) ? DIGIT_W'(BCD_TOP) : din;
    end

    assign up_limit = g_digit[NDIGITS-1].cout;
    assign dn_limit = g_digit[NDIGITS-1].bout;

    // Pack per-digit candidates back into count-wide vectors.
    always_comb begin
        up_vec = '0;
        dn_vec = '0;
        ld_vec = '0;
        for (int i = 0; i < NDIGITS; i++) begin
            up_vec[i*DIGIT_W +: DIGIT_W] = up_d[i];
            dn_vec[i*DIGIT_W +: DIGIT_W] = dn_d[i];
            ld_vec[i*DIGIT_W +: DIGIT_W] = ld_d[i];
        end
    end

    assign max_val = bcd_mode ? {NDIGITS{DIGIT_W'(BCD_TOP)}} : '1;

    assign tc = en && !load && ((up && (count == max_val)) || (!up && (count == '0)));

    // Count next-state: load beats enable; limits either wrap (pulse) or hold.
    always_comb begin
        count_next = count;
        wrap_next  = 1'b0;
        if (load) begin
            count_next = ld_vec;
        end else if (en) begin
            if (up) begin
                if (!(up_limit && saturate)) begin
                    count_next = up_vec;
                    wrap_next  = up_limit;
                end
            end else begin
                if (!(dn_limit && saturate)) begin
                    count_next = dn_vec;
                    wrap_next  = dn_limit;
                end
            end
        end
    end

    // Scan divider and digit index, free-running.
    always_comb begin
        div_next = div_q + DIV_W'(1);
        idx_next = idx_q;
        if (div_q == DIV_W'(SCAN_DIV - 1)) begin
            div_next = '0;
            idx_next = (idx_q == IDX_W'(NDIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Display is built from next-state values so seg always matches count and dig_sel.
    assign sel_digit = count_next[idx_next*DIGIT_W +: DIGIT_W];

    seg7_decoder u_seg7_decoder (
        .digit      (sel_digit),
        .segments_c (sel_segs)
    );

    always_comb begin
        dig_sel_next  = NDIGITS'(1) << idx_next;
        seg_next.dp   = saturate && (idx_next == '0);
        seg_next.segs = sel_segs;
    end

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            count   <= '0;
            wrap    <= 1'b0;
            div_q   <= '0;
            idx_q   <= '0;
            dig_sel <= NDIGITS'(1);
            seg     <= {1'b0, SEG_0};
        end else begin
            count   <= count_next;
            wrap    <= wrap_next;
            div_q   <= div_next;
            idx_q   <= idx_next;
            dig_sel <= dig_sel_next;
            seg     <= seg_next;
        end
    end

endmodule

// File: tb/tb_updown_digit_counter.sv
// Directed vector bench for updown_digit_counter with NDIGITS=2, SCAN_DIV=4.
module tb_updown_digit_counter;

    logic       clk_2 = 1'b0;
    logic       clk_run = 1'b1;
    logic       reset;
    logic       en;
    logic       up;
    logic       load;
    logic [7:0] data_in;
    logic       bcd_mode;
    logic       saturate;
    logic [7:0] count;
    logic       tc;
    logic       wrap;
    logic [7:0] seg;
    logic [1:0] dig_sel;

    int checks = 0;
    int errors = 0;

    updown_digit_counter #(.NDIGITS(2), .SCAN_DIV(4)) dut (
        .clk_2    (clk_2),
        .reset    (reset),
        .en       (en),
        .up       (up),
        .load     (load),
        .data_in  (data_in),
        .bcd_mode (bcd_mode),
        .saturate (saturate),
        .count    (count),
        .tc       (tc),
        .wrap     (wrap),
        .seg      (seg),
        .dig_sel  (dig_sel)
    );

    always #5 if (clk_run) clk_2 = ~clk_2;

    typedef struct {
        logic       load;
        logic       en;
        logic       up;
        logic       bcd;
        logic       sat;
        logic [7:0] data;
        logic       exp_tc;
        logic [7:0] exp_count;
        logic       exp_wrap;
    } vec_t;

    localparam int NVEC = 25;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] prev;
        logic [1:0] cur;
        logic       changed;
        logic       sat_phase;

        //              ld  en  up  bcd sat data    tc  count  wrap
        vecs[0]  = '{1'b1,1'b0,1'b1,1'b1,1'b0,8'h98, 1'b0,8'h98,1'b0};
        vecs[1]  = '{1'b0,1'b1,1'b1,1'b1,1'b0,8'h00, 1'b0,8'h99,1'b0};
        vecs[2]  = '{1'b0,1'b1,1'b1,1'b1,1'b0,8'h00, 1'b1,8'h00,1'b1};
        vecs[3]  = '{1'b0,1'b1,1'b1,1'b1,1'b0,8'h00, 1'b0,8'h01,1'b0};
        vecs[4]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,8'h01, 1'b0,8'h01,1'b0};
        vecs[5]  = '{1'b0,1'b1,1'b0,1'b0,1'b1,8'h00, 1'b0,8'h00,1'b0};
        vecs[6]  = '{1'b0,1'b1,1'b0,1'b0,1'b1,8'h00, 1'b1,8'h00,1'b0};
        vecs[7]  = '{1'b0,1'b1,1'b0,1'b0,1'b1,8'h00, 1'b1,8'h00,1'b0};
        vecs[8]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,8'hAF, 1'b0,8'h99,1'b0};
        vecs[9]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,8'h00, 1'b0,8'h98,1'b0};
        vecs[10] = '{1'b1,1'b0,1'b1,1'b0,1'b0,8'h0F, 1'b0,8'h0F,1'b0};
        vecs[11] = '{1'b0,1'b1,1'b1,1'b0,1'b0,8'h00, 1'b0,8'h10,1'b0};
        vecs[12] = '{1'b1,1'b1,1'b1,1'b0,1'b0,8'h42, 1'b0,8'h42,1'b0};
        vecs[13] = '{1'b1,1'b0,1'b0,1'b0,1'b0,8'h00, 1'b0,8'h00,1'b0};
        vecs[14] = '{1'b0,1'b1,1'b0,1'b0,1'b0,8'h00, 1'b1,8'hFF,1'b1};
        vecs[15] = '{1'b0,1'b0,1'b0,1'b0,1'b0,8'h00, 1'b0,8'hFF,1'b0};
        vecs[16] = '{1'b0,1'b1,1'b1,1'b0,1'b0,8'h00, 1'b1,8'h00,1'b1};
        vecs[17] = '{1'b1,1'b0,1'b1,1'b1,1'b1,8'h99, 1'b0,8'h99,1'b0};
        vecs[18] = '{1'b0,1'b1,1'b1,1'b1,1'b1,8'h00, 1'b1,8'h99,1'b0};
        vecs[19] = '{1'b1,1'b0,1'b1,1'b0,1'b0,8'hA5, 1'b0,8'hA5,1'b0};
        vecs[20] = '{1'b0,1'b1,1'b1,1'b1,1'b0,8'h00, 1'b0,8'hA6,1'b0};
        vecs[21] = '{1'b1,1'b0,1'b0,1'b0,1'b0,8'hA0, 1'b0,8'hA0,1'b0};
        vecs[22] = '{1'b0,1'b1,1'b0,1'b1,1'b0,8'h00, 1'b0,8'h89,1'b0};
        vecs[23] = '{1'b1,1'b0,1'b0,1'b0,1'b0,8'hAF, 1'b0,8'hAF,1'b0};
        vecs[24] = '{1'b0,1'b0,1'b1,1'b1,1'b0,8'h00, 1'b0,8'hAF,1'b0};

        reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0;
        data_in = 8'h00; bcd_mode = 1'b0; saturate = 1'b0;

        #12;
        check("reset_count",   32'(count),   32'h00);
        check("reset_wrap",    32'(wrap),    32'h0);
        check("reset_dig_sel", 32'(dig_sel), 32'h1);
        check("reset_seg",     32'(seg),     32'h3F);

        @(negedge clk_2);
        reset = 1'b0;

        // Table vectors: tc checked before the edge, count/wrap after it.
        @(negedge clk_2);
        for (int i = 0; i < NVEC; i++) begin
            load = vecs[i].load; en = vecs[i].en; up = vecs[i].up;
            bcd_mode = vecs[i].bcd; saturate = vecs[i].sat; data_in = vecs[i].data;
            #1;
            check($sformatf("vec%0d_tc", i), 32'(tc), 32'(vecs[i].exp_tc));
            @(negedge clk_2);
            check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
            check($sformatf("vec%0d_wrap", i),  32'(wrap),  32'(vecs[i].exp_wrap));
        end

        // Asynchronous reset while wrap is high, clock parked low.
        load = 1'b1; en = 1'b0; bcd_mode = 1'b0; saturate = 1'b0; data_in = 8'h00;
        @(negedge clk_2);
        load = 1'b0; en = 1'b1; up = 1'b0;
        @(negedge clk_2);
        check("pre_reset_count", 32'(count), 32'hFF);
        check("pre_reset_wrap",  32'(wrap),  32'h1);
        clk_run = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("async_clk_low",       32'(clk_2),   32'h0);
        check("async_reset_count",   32'(count),   32'h00);
        check("async_reset_wrap",    32'(wrap),    32'h0);
        check("async_reset_dig_sel", 32'(dig_sel), 32'h1);
        check("async_reset_seg",     32'(seg),     32'h3F);
        en = 1'b0;
        #5 reset = 1'b0;
        #2 clk_run = 1'b1;

        // Scan: load 3A in hex mode and watch the digit multiplexing.
        @(negedge clk_2);
        load = 1'b1; data_in = 8'h3A;
        @(negedge clk_2);
        load = 1'b0;

        prev = dig_sel;
        changed = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk_2);
            if (dig_sel != prev) begin
                changed = 1'b1;
                break;
            end
        end
        check("scan_advances", 32'(changed), 32'h1);
        cur = (dig_sel == 2'b10) ? 2'b10 : 2'b01;
        sat_phase = 1'b0;
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 4; k++) begin
                if (!(r == 0 && k == 0)) @(negedge clk_2);
                check($sformatf("scan_r%0d_k%0d_dig_sel", r, k), 32'(dig_sel), 32'(cur));
                check($sformatf("scan_r%0d_k%0d_seg", r, k), 32'(seg),
                      (cur == 2'b01) ? 32'({sat_phase, 7'h77}) : 32'h4F);
            end
            cur = {cur[0], cur[1]};
            if (r == 2) begin
                saturate  = 1'b1;
                sat_phase = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
